pipe_hazard_ctrl: RTL

Parametrised pipeline control block for the light RV32I core, replacing the tied-off stage stalls. It tracks per-stage valid bits and destination-register info for an N-stage pipeline. From these it produces per-stage stall and flush controls, decode-time forwarding selects, load-use interlocks and branch/jump redirect flushes. It also keeps saturating stall and flush performance counters, and sits beside the stage modules inside the CPU top.

---
 rtl/pipe_hazard_ctrl_if.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 81 ++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode-side hazard inputs and per-stage pipeline controls
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
);
  localparam int SW = $clog2(NUM_STAGES);
  logic fetch_valid;
  logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic dec_rs1_used, dec_rs2_used, dec_reg_wr, dec_is_load;
  logic redirect, ext_stall;
  logic [NUM_STAGES-1:0] stall, flush, stage_valid;
  logic [SW-1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output fetch_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd,
           dec_reg_wr, dec_is_load, redirect, ext_stall,
    input  stall, flush, stage_valid, fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
  );
  modport slave (
    input  fetch_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd,
           dec_reg_wr, dec_is_load, redirect, ext_stall,
    output stall, flush, stage_valid, fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage valid tracking, forwarding selects, load-use and redirect control
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int REDIRECT_STAGE = 2,
  parameter int LOAD_READY_STAGE = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int N = NUM_STAGES;
  localparam int SW = $clog2(NUM_STAGES);
  logic [N-1:0] v;
  logic [N-1:1] wr, ld;
  logic [REG_ADDR_W-1:0] rd [1:N-1];
  logic [SW-1:0] s1, s2;
  logic lu1, lu2, lu, redir;
  logic [CNT_W-1:0] sc, fc;
  // scan oldest to youngest so the youngest (smallest k) match wins
  always_comb begin
    s1 = '0;
    s2 = '0;
    lu1 = 1'b0;
    lu2 = 1'b0;
    for (int k = N-1; k >= 1; k--) begin
      if (v[k] && wr[k] && rd[k] == bus.dec_rs1 && bus.dec_rs1 != '0 && bus.dec_rs1_used) begin
        s1 = SW'(k);
        lu1 = ld[k] && k < LOAD_READY_STAGE;
      end
      if (v[k] && wr[k] && rd[k] == bus.dec_rs2 && bus.dec_rs2 != '0 && bus.dec_rs2_used) begin
        s2 = SW'(k);
        lu2 = ld[k] && k < LOAD_READY_STAGE;
      end
    end
  end
  assign redir = bus.redirect && v[REDIRECT_STAGE];
  assign lu = v[0] && (lu1 || lu2);
  assign bus.stall = bus.ext_stall ? '1 : N'(lu && !redir);
  assign bus.flush = bus.ext_stall ? '0 : redir ? N'((1 << (REDIRECT_STAGE+1)) - 1) : lu ? N'(2) : '0;
  assign bus.fwd_rs1_sel = s1;
  assign bus.fwd_rs2_sel = s2;
  assign bus.stage_valid = v;
  assign bus.stall_cnt = sc;
  assign bus.flush_cnt = fc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
      wr <= '0;
      ld <= '0;
      for (int k = 1; k < N; k++) rd[k] <= '0;
      sc <= '0;
      fc <= '0;
    end else if (!bus.ext_stall) begin
      for (int k = 2; k < N; k++) begin
        v[k] <= v[k-1];
        rd[k] <= rd[k-1];
        wr[k] <= wr[k-1];
        ld[k] <= ld[k-1];
      end
      if (lu && !redir) begin
        v[1] <= 1'b0;
        wr[1] <= 1'b0;
        ld[1] <= 1'b0;
        sc <= sc + CNT_W'(~&sc);
      end else begin
        v[0] <= bus.fetch_valid;
        v[1] <= v[0];
        rd[1] <= bus.dec_rd;
        wr[1] <= bus.dec_reg_wr;
        ld[1] <= bus.dec_is_load;
      end
      // redirect squashes the young entries after the normal shift above
      if (redir) begin
        for (int k = 0; k <= REDIRECT_STAGE; k++) v[k] <= 1'b0;
        fc <= fc + CNT_W'(~&fc);
      end
    end
  end
endmodule
